// File: rtl/accum_op_sequencer.sv
// rtl/accum_op_sequencer.sv - tagged command FIFO and issue sequencer for the registered accumulator
// Optional overflow sticky flag (Clr_Ovf/Ovf_Sticky) enabled by defining OVF_STICKY_EN.
module accum_op_sequencer #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int TW    = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Cmd_Valid,
  output logic          Cmd_Ready,
  input  logic [1:0]    Cmd_Op,
  input  logic [N-1:0]  Cmd_Data,
  input  logic [TW-1:0] Cmd_Tag,
  input  logic          Flush,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic          Sel,
  output logic          AddSub,
  input  logic [N-1:0]  Z,
  input  logic          Overflow,
  output logic          Res_Valid,
  output logic [N-1:0]  Res_Z,
  output logic          Res_Ovf,
  output logic [TW-1:0] Res_Tag,
  output logic [LW-1:0] Level,
`ifdef OVF_STICKY_EN
  input  logic          Clr_Ovf,
  output logic          Ovf_Sticky,
`endif
  output logic          Busy
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e state_q;

  logic [1:0]    op_mem   [DEPTH];
  logic [N-1:0]  data_mem [DEPTH];
  logic [TW-1:0] tag_mem  [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic [N-1:0]  a_q, b_q, a_d, b_d;
  logic          sel_q, addsub_q, sel_d, addsub_d;

  logic [2:0]    vld_q;
  logic [TW-1:0] tag_q [3];

  logic          res_valid_q, res_ovf_q;
  logic [N-1:0]  res_z_q;
  logic [TW-1:0] res_tag_q;

  logic full, empty, push, pop, flush_now;
  logic [1:0]    head_op;
  logic [N-1:0]  head_data;
  logic [TW-1:0] head_tag;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign Cmd_Ready = !full && !Flush && (state_q != ST_FLUSH);
  assign push      = Cmd_Valid && Cmd_Ready;
  assign flush_now = Flush && (state_q == ST_IDLE);
  // The flush edge never issues, so the dropped head cannot leak out.
  assign pop       = (state_q == ST_IDLE) && !Flush && !empty;

  assign head_op   = op_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign head_tag  = tag_mem[rd_ptr_q];

  always_ff @(posedge Clock) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= Cmd_Op;
      data_mem[wr_ptr_q] <= Cmd_Data;
      tag_mem[wr_ptr_q]  <= Cmd_Tag;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_now) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // Default is the hold bubble: Sel=1 with B=0 feeds Z back unchanged.
  always_comb begin
    a_d      = '0;
    b_d      = '0;
    sel_d    = 1'b1;
    addsub_d = 1'b0;
    if (pop) begin
      case (head_op)
        OP_LOAD: begin
          a_d   = head_data;
          sel_d = 1'b0;
        end
        OP_ADD: b_d = head_data;
        OP_SUB: begin
          b_d      = head_data;
          addsub_d = 1'b1;
        end
        default: sel_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 1'b1;
      addsub_q    <= 1'b0;
      vld_q       <= '0;
      tag_q[0]    <= '0;
      tag_q[1]    <= '0;
      tag_q[2]    <= '0;
      res_valid_q <= 1'b0;
      res_z_q     <= '0;
      res_ovf_q   <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      addsub_q <= addsub_d;

      // Stage 2 lines up with Z being valid for the op issued three edges earlier.
      vld_q    <= {vld_q[1:0], pop};
      tag_q[0] <= head_tag;
      tag_q[1] <= tag_q[0];
      tag_q[2] <= tag_q[1];

      res_valid_q <= vld_q[2];
      if (vld_q[2]) begin
        res_z_q   <= Z;
        res_ovf_q <= Overflow;
        res_tag_q <= tag_q[2];
      end

      case (state_q)
        ST_IDLE:  if (Flush) state_q <= ST_FLUSH;
        ST_FLUSH: if (vld_q == '0) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef OVF_STICKY_EN
  logic ovf_sticky_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ovf_sticky_q <= 1'b0;
    end else if (res_valid_q && res_ovf_q) begin
      ovf_sticky_q <= 1'b1;
    end else if (Clr_Ovf) begin
      ovf_sticky_q <= 1'b0;
    end
  end

  assign Ovf_Sticky = ovf_sticky_q;
`endif

  assign A         = a_q;
  assign B         = b_q;
  assign Sel       = sel_q;
  assign AddSub    = addsub_q;
  assign Res_Valid = res_valid_q;
  assign Res_Z     = res_z_q;
  assign Res_Ovf   = res_ovf_q;
  assign Res_Tag   = res_tag_q;
  assign Level     = level_q;
  assign Busy      = !empty || (vld_q != '0) || (state_q == ST_FLUSH);

endmodule
